// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the serial link: the sync header that the
// transmitter sends and the detector looks for, plus the transmitter's state codes.
package serial_link_pkg;

  localparam int SYNC_WIDTH = 4;
  localparam logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'b1101;

  // Transmitter FSM states, 2-bit binary encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Counter width: enough to hold the largest phase length minus one, never zero bits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/frame_serializer_moore.sv
// Moore bit-serial frame transmitter: sync header then payload, MSB first, followed
// by a fixed idle gap so the receiving detector settles back to its start state.
module frame_serializer_moore
  import serial_link_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = SYNC_WIDTH,
  parameter logic [SYNC_W-1:0] SYNC      = SYNC_PATTERN,
  parameter int                IDLE_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = cnt_width(SYNC_W, DATA_W, IDLE_BITS);
  localparam logic [CW-1:0] CNT_SYNC = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] CNT_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_GAP  = CW'(IDLE_BITS - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [CW-1:0]     cnt_dec;
  logic [SYNC_W-1:0] sync_sh;
  logic [DATA_W-1:0] shift_nxt;

  // Handshake: a word is taken on a rising edge where load_valid && load_ready;
  // load_ready depends on registered state only, and load_valid while busy is ignored.
  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_done = done_q;

  assign cnt_dec   = cnt_q - CW'(1);
  assign sync_sh   = SYNC >> cnt_dec;
  assign shift_nxt = shift_q << 1;

  // dout_q always holds the bit for the current cycle, so the next bit is chosen here.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dout_d  = 1'b0;
        valid_d = 1'b0;
        if (load_valid) begin
          shift_d = load_data;
          cnt_d   = CNT_SYNC;
          state_d = ST_SYNC;
          dout_d  = SYNC[SYNC_W-1];
          valid_d = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CNT_DATA;
          dout_d  = shift_q[DATA_W-1];
        end else begin
          cnt_d  = cnt_dec;
          dout_d = sync_sh[0];
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_GAP;
          dout_d  = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_dec;
          shift_d = shift_nxt;
          dout_d  = shift_nxt[DATA_W-1];
        end
      end
      ST_GAP: begin
        dout_d  = 1'b0;
        valid_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dout_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule
